// File: rtl/sd_multilevel_mod.sv
// ---------------------------------------------------------------------------
// sd_multilevel_mod
//
// Multi-level sigma-delta modulator with a selectable 1st or 2nd loop order.
// The signed drive word is held in x_q. Each enabled cycle it is pushed
// through one or two saturating integrators. The result is then quantized
// into one of LEVELS codes. Feedback uses the level of the code that is
// currently registered.
//
// Parameters
//   BITWIDTH : width of the signed input word, full scale H = 2^(BITWIDTH-1)
//   LEVELS   : number of quantizer levels L (2..16)
//   ACCW     : signed integrator width (>= BITWIDTH+1)
//
// Ports
//   clk       : system clock, all state on rising edge
//   reset     : asynchronous active-low reset
//   en        : advance the loop one step when 1, freeze loop state when 0
//   order_sel : 0 = first order, 1 = second order
//   kin       : signed input sample
//   kin_valid : load kin into the held input register
//   sat_clr   : clear the sticky saturation flag
//   sd_code   : registered quantizer code 0..L-1
//   sd_therm  : thermometer form of sd_code, bit k = (sd_code > k)
//   sat_flag  : sticky flag, set when any integrator clamps
// ---------------------------------------------------------------------------
module sd_multilevel_mod #(
   parameter int BITWIDTH = 32,
   parameter int LEVELS   = 2,
   parameter int ACCW     = BITWIDTH + 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      en,
   input  logic                      order_sel,
   input  logic [BITWIDTH-1:0]       kin,
   input  logic                      kin_valid,
   input  logic                      sat_clr,
   output logic [$clog2(LEVELS)-1:0] sd_code,
   output logic [LEVELS-2:0]         sd_therm,
   output logic                      sat_flag
);

   localparam int LW = $clog2(LEVELS);
   // Two guard bits: acc + x - y (and acc2 + a1 - y) can never wrap before the clamp.
   localparam int IW = ACCW + 2;

   localparam logic signed [IW-1:0] ONE_C      = {{(IW-1){1'b0}}, 1'b1};
   localparam logic signed [IW-1:0] H_C        = ONE_C <<< (BITWIDTH - 1);
   localparam logic signed [IW-1:0] LM1_C      = IW'(LEVELS - 1);
   localparam logic signed [IW-1:0] STEP_C     = H_C / LM1_C;
   localparam logic signed [IW-1:0] ACC_MAX_C  = (ONE_C <<< (ACCW - 1)) - ONE_C;
   localparam logic signed [IW-1:0] ACC_MIN_C  = -(ONE_C <<< (ACCW - 1));
   localparam logic [LW-1:0]        RESET_CODE_C = LW'(LEVELS / 2);
   localparam logic [LW-1:0]        CODE_INC_C   = LW'(1'b1);

   // Clamp a wide intermediate to the integrator range.
   function automatic logic signed [IW-1:0] clamp_fn(input logic signed [IW-1:0] v);
      logic signed [IW-1:0] r;
      if (v > ACC_MAX_C) begin
         r = ACC_MAX_C;
      end else if (v < ACC_MIN_C) begin
         r = ACC_MIN_C;
      end else begin
         r = v;
      end
      return r;
   endfunction

   // True only when the value is strictly outside the integrator range.
   function automatic logic clip_fn(input logic signed [IW-1:0] v);
      return (v > ACC_MAX_C) || (v < ACC_MIN_C);
   endfunction

   // Feedback level of code q: (2q - (L-1)) * STEP.
   function automatic logic signed [IW-1:0] level_fn(input logic [LW-1:0] q);
      logic signed [IW-1:0] qs;
      qs = IW'({1'b0, q});
      return (qs + qs - LM1_C) * STEP_C;
   endfunction

   // Quantizer: number of thresholds t_k = (2k - (L-2)) * STEP that u reaches.
   function automatic logic [LW-1:0] quant_fn(input logic signed [IW-1:0] u);
      logic [LW-1:0]        cnt;
      logic signed [IW-1:0] kk;
      cnt = '0;
      for (int k = 0; k < LEVELS - 1; k++) begin
         kk = IW'(2 * k - (LEVELS - 2));
         if (u >= kk * STEP_C) begin
            cnt = cnt + CODE_INC_C;
         end else begin
            cnt = cnt;
         end
      end
      return cnt;
   endfunction

   logic [BITWIDTH-1:0]    x_q,     x_d;
   logic signed [ACCW-1:0] acc1_q,  acc1_d;
   logic signed [ACCW-1:0] acc2_q,  acc2_d;
   logic [LW-1:0]          code_q,  code_d;
   logic                   sat_q,   sat_d;
   logic                   order_q, order_d;

   logic signed [IW-1:0]   y_s;
   logic signed [IW-1:0]   a1_raw_s, a1_sat_s;
   logic signed [IW-1:0]   a2_raw_s, a2_sat_s;
   logic                   a1_hit_s, a2_hit_s;

   // Loop datapath: both integrator stages are evaluated from the current state.
   always_comb begin
      y_s      = level_fn(code_q);
      a1_raw_s = IW'(acc1_q) + IW'($signed(x_q)) - y_s;
      a1_sat_s = clamp_fn(a1_raw_s);
      a1_hit_s = clip_fn(a1_raw_s);
      a2_raw_s = IW'(acc2_q) + a1_sat_s - y_s;
      a2_sat_s = clamp_fn(a2_raw_s);
      a2_hit_s = clip_fn(a2_raw_s);
   end

   // Next-state selection: an order change overrides the loop update; en gates the loop.
   always_comb begin
      x_d     = x_q;
      acc1_d  = acc1_q;
      acc2_d  = acc2_q;
      code_d  = code_q;
      order_d = order_q;
      sat_d   = sat_q & ~sat_clr;

      // The input register is loaded independently of en and order changes.
      if (kin_valid) begin
         x_d = kin;
      end else begin
         x_d = x_q;
      end

      if (order_sel != order_q) begin
         order_d = order_sel;
         acc1_d  = '0;
         acc2_d  = '0;
         code_d  = RESET_CODE_C;
      end else if (en) begin
         acc1_d = a1_sat_s[ACCW-1:0];
         if (order_q) begin
            acc2_d = a2_sat_s[ACCW-1:0];
            code_d = quant_fn(a2_sat_s);
            // A set in the same cycle as a clear takes priority.
            sat_d  = a1_hit_s | a2_hit_s | (sat_q & ~sat_clr);
         end else begin
            acc2_d = '0;
            code_d = quant_fn(a1_sat_s);
            sat_d  = a1_hit_s | (sat_q & ~sat_clr);
         end
      end else begin
         code_d = code_q;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x_q     <= '0;
         acc1_q  <= '0;
         acc2_q  <= '0;
         code_q  <= RESET_CODE_C;
         sat_q   <= 1'b0;
         order_q <= 1'b0;
      end else begin
         x_q     <= x_d;
         acc1_q  <= acc1_d;
         acc2_q  <= acc2_d;
         code_q  <= code_d;
         sat_q   <= sat_d;
         order_q <= order_d;
      end
   end

   // Thermometer decode of the registered code, no extra pipeline stage.
   always_comb begin
      sd_therm = '0;
      for (int k = 0; k < LEVELS - 1; k++) begin
         sd_therm[k] = (code_q > LW'(k));
      end
   end

   assign sd_code  = code_q;
   assign sat_flag = sat_q;

endmodule

// File: tb/tb_sd_multilevel_mod.sv
// ---------------------------------------------------------------------------
// tb_sd_multilevel_mod
//
// Four modulator instances share one stimulus stream:
//   u0 : L=2, ACCW=20
//   u1 : L=3, ACCW=20
//   u2 : L=2, ACCW=17 (BITWIDTH+1, so it saturates easily)
//   u3 : L=5, ACCW=20
// A reference model written directly from the loop equations pushes one
// expected record per instance into a queue when each cycle is driven. The
// record is popped and compared after the clock edge. Hand-derived vectors
// and sequences add fixed expectations for the documented corner cases.
// ---------------------------------------------------------------------------
module tb_sd_multilevel_mod;

   localparam int     BW = 16;
   localparam longint HH = 64'sd32768;

   logic clk = 1'b0;
   logic reset, en, order_sel, kin_valid, sat_clr;
   logic [BW-1:0] kin;

   logic [0:0] code0, therm0;
   logic [1:0] code1, therm1;
   logic [0:0] code2, therm2;
   logic [2:0] code3;
   logic [3:0] therm3;
   logic       flag0, flag1, flag2, flag3;

   always #5 clk = ~clk;

   sd_multilevel_mod #(.BITWIDTH(BW), .LEVELS(2), .ACCW(20)) u0 (
      .clk(clk), .reset(reset), .en(en), .order_sel(order_sel), .kin(kin),
      .kin_valid(kin_valid), .sat_clr(sat_clr), .sd_code(code0),
      .sd_therm(therm0), .sat_flag(flag0));
   sd_multilevel_mod #(.BITWIDTH(BW), .LEVELS(3), .ACCW(20)) u1 (
      .clk(clk), .reset(reset), .en(en), .order_sel(order_sel), .kin(kin),
      .kin_valid(kin_valid), .sat_clr(sat_clr), .sd_code(code1),
      .sd_therm(therm1), .sat_flag(flag1));
   sd_multilevel_mod #(.BITWIDTH(BW), .LEVELS(2), .ACCW(17)) u2 (
      .clk(clk), .reset(reset), .en(en), .order_sel(order_sel), .kin(kin),
      .kin_valid(kin_valid), .sat_clr(sat_clr), .sd_code(code2),
      .sd_therm(therm2), .sat_flag(flag2));
   sd_multilevel_mod #(.BITWIDTH(BW), .LEVELS(5), .ACCW(20)) u3 (
      .clk(clk), .reset(reset), .en(en), .order_sel(order_sel), .kin(kin),
      .kin_valid(kin_valid), .sat_clr(sat_clr), .sd_code(code3),
      .sd_therm(therm3), .sat_flag(flag3));

   logic [3:0]         obs_code  [4];
   logic [15:0]        obs_therm [4];
   logic               obs_flag  [4];
   logic signed [63:0] obs_acc1  [4];
   logic signed [63:0] obs_acc2  [4];

   assign obs_code[0] = 4'(code0);  assign obs_therm[0] = 16'(therm0); assign obs_flag[0] = flag0;
   assign obs_code[1] = 4'(code1);  assign obs_therm[1] = 16'(therm1); assign obs_flag[1] = flag1;
   assign obs_code[2] = 4'(code2);  assign obs_therm[2] = 16'(therm2); assign obs_flag[2] = flag2;
   assign obs_code[3] = 4'(code3);  assign obs_therm[3] = 16'(therm3); assign obs_flag[3] = flag3;
   assign obs_acc1[0] = 64'(u0.acc1_q); assign obs_acc2[0] = 64'(u0.acc2_q);
   assign obs_acc1[1] = 64'(u1.acc1_q); assign obs_acc2[1] = 64'(u1.acc2_q);
   assign obs_acc1[2] = 64'(u2.acc1_q); assign obs_acc2[2] = 64'(u2.acc2_q);
   assign obs_acc1[3] = 64'(u3.acc1_q); assign obs_acc2[3] = 64'(u3.acc2_q);

   int lv [4] = '{2, 3, 2, 5};
   int aw [4] = '{20, 20, 17, 20};

   longint m_acc1 [4];
   longint m_acc2 [4];
   longint m_x    [4];
   longint m_code [4];
   bit     m_flag [4];
   bit     m_order[4];

   typedef struct packed {
      logic [3:0]  code;
      logic [15:0] therm;
      logic        flag;
      logic [63:0] acc1;
      logic [63:0] acc2;
   } exp_t;

   exp_t sbq [4][$];

   typedef struct {
      bit     e;
      bit     os;
      bit     kv;
      longint k;
      bit     clr;
      int     c0;   // expected u0 code, -1 = model only
      int     c1;   // expected u1 code, -1 = model only
   } vec_t;

   vec_t tbl [18];

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string nm, input int inst, input longint act, input longint want);
      n_checks++;
      if (act != want) begin
         n_err++;
         $display("FAIL %s u%0d: got %0d, want %0d (t=%0t)", nm, inst, act, want, $time);
      end
   endtask

   function automatic longint therm_of(input longint c, input int l);
      longint t;
      t = 0;
      for (int k = 0; k < l - 1; k++) begin
         if (c > k) t = t | (64'sd1 << k);
      end
      return t;
   endfunction

   function automatic longint clampv(input longint v, input int w, output bit hit);
      longint lo, hi;
      lo  = -(64'sd1 <<< (w - 1));
      hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
      hit = (v < lo) || (v > hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_acc1[i]  = 0;
         m_acc2[i]  = 0;
         m_x[i]     = 0;
         m_code[i]  = lv[i] / 2;
         m_flag[i]  = 1'b0;
         m_order[i] = 1'b0;
      end
   endtask

   task automatic model_step(input int i, input bit e, input bit os, input bit kv,
                             input longint k, input bit clr);
      longint step, y, a1, a2, u;
      bit     h1, h2;
      int     cnt;
      exp_t   ex;
      step = HH / (lv[i] - 1);
      h1 = 1'b0;
      h2 = 1'b0;
      if (os != m_order[i]) begin
         m_order[i] = os;
         m_acc1[i]  = 0;
         m_acc2[i]  = 0;
         m_code[i]  = lv[i] / 2;
         m_flag[i]  = m_flag[i] & !clr;
      end else if (e) begin
         y  = (2 * m_code[i] - (lv[i] - 1)) * step;
         a1 = clampv(m_acc1[i] + m_x[i] - y, aw[i], h1);
         if (m_order[i]) begin
            a2 = clampv(m_acc2[i] + a1 - y, aw[i], h2);
            u  = a2;
         end else begin
            a2 = 0;
            u  = a1;
         end
         cnt = 0;
         for (int t = 0; t < lv[i] - 1; t++) begin
            if (u >= (2 * t - (lv[i] - 2)) * step) cnt++;
         end
         m_acc1[i] = a1;
         m_acc2[i] = a2;
         m_code[i] = cnt;
         m_flag[i] = h1 | h2 | (m_flag[i] & !clr);
      end else begin
         m_flag[i] = m_flag[i] & !clr;
      end
      if (kv) m_x[i] = k;
      ex.code  = 4'(m_code[i]);
      ex.therm = 16'(therm_of(m_code[i], lv[i]));
      ex.flag  = m_flag[i];
      ex.acc1  = m_acc1[i];
      ex.acc2  = m_acc2[i];
      sbq[i].push_back(ex);
   endtask

   // Drive one cycle, let the model predict it, then compare after the edge.
   task automatic cycle(input bit e, input bit os, input bit kv, input longint k, input bit clr);
      exp_t ex;
      en        = e;
      order_sel = os;
      kin_valid = kv;
      kin       = k[BW-1:0];
      sat_clr   = clr;
      for (int i = 0; i < 4; i++) model_step(i, e, os, kv, k, clr);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (sbq[i].size() == 0) begin
            check("sb_empty", i, 0, 1);
         end else begin
            ex = sbq[i].pop_front();
            check("code",  i, obs_code[i],  ex.code);
            check("therm", i, obs_therm[i], ex.therm);
            check("flag",  i, obs_flag[i],  ex.flag);
            check("acc1",  i, obs_acc1[i],  longint'(ex.acc1));
            check("acc2",  i, obs_acc2[i],  longint'(ex.acc2));
         end
      end
   endtask

   task automatic check_reset(input string nm);
      for (int i = 0; i < 4; i++) begin
         check({nm, "_code"},  i, obs_code[i],  lv[i] / 2);
         check({nm, "_therm"}, i, obs_therm[i], therm_of(lv[i] / 2, lv[i]));
         check({nm, "_flag"},  i, obs_flag[i],  0);
         check({nm, "_acc1"},  i, obs_acc1[i],  0);
         check({nm, "_acc2"},  i, obs_acc2[i],  0);
      end
   endtask

   function automatic vec_t mk(input bit e, input bit kv, input longint k, input int c0, input int c1);
      vec_t v;
      v.e = e; v.os = 1'b0; v.kv = kv; v.k = k; v.clr = 1'b0; v.c0 = c0; v.c1 = c1;
      return v;
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // x = 0 gives 0,1,0,1 on L=2 and constant 1 on L=3.
      tbl[0]  = mk(1'b1, 1'b0, 0, 0, 1);
      tbl[1]  = mk(1'b1, 1'b0, 0, 1, 1);
      tbl[2]  = mk(1'b1, 1'b0, 0, 0, 1);
      tbl[3]  = mk(1'b1, 1'b0, 0, 1, 1);
      // Load H/2 while frozen; then a 0,1,1,1 pattern with a 5-cycle freeze inside.
      tbl[4]  = mk(1'b0, 1'b1, HH / 2, 1, 1);
      tbl[5]  = mk(1'b1, 1'b0, 0, 0, -1);
      tbl[6]  = mk(1'b1, 1'b0, 0, 1, -1);
      tbl[7]  = mk(1'b1, 1'b0, 0, 1, -1);
      for (int r = 8; r < 13; r++) tbl[r] = mk(1'b0, 1'b0, 0, 1, -1);
      tbl[13] = mk(1'b1, 1'b0, 0, 1, -1);
      tbl[14] = mk(1'b1, 1'b0, 0, 0, -1);
      tbl[15] = mk(1'b1, 1'b0, 0, 1, -1);
      tbl[16] = mk(1'b1, 1'b0, 0, 1, -1);
      tbl[17] = mk(1'b1, 1'b0, 0, 1, -1);

      reset = 1'b0; en = 1'b0; order_sel = 1'b0; kin_valid = 1'b0; sat_clr = 1'b0; kin = '0;
      model_reset();
      @(posedge clk);
      #1;
      check_reset("rst");
      reset = 1'b1;

      // Table-driven first-order vectors.
      for (int r = 0; r < 18; r++) begin
         cycle(tbl[r].e, tbl[r].os, tbl[r].kv, tbl[r].k, tbl[r].clr);
         if (tbl[r].c0 >= 0) check("tbl_c0", 0, obs_code[0], tbl[r].c0);
         if (tbl[r].c1 >= 0) check("tbl_c1", 1, obs_code[1], tbl[r].c1);
         if (tbl[r].c1 == 1) check("tbl_t1", 1, obs_therm[1], 1);
         if (r >= 5 && tbl[r].e) check("l3_band", 1, (obs_code[1] == 4'd1 || obs_code[1] == 4'd2), 1);
         check("tbl_f0", 0, obs_flag[0], 0);
      end

      // Second order, full negative drive: u2 clamps on the first enabled edge.
      cycle(1'b0, 1'b1, 1'b1, -HH, 1'b0);
      check("oc_code", 2, obs_code[2], 1);
      cycle(1'b1, 1'b1, 1'b0, 0, 1'b0);
      check("sat_acc2", 2, obs_acc2[2], -64'sd65536);
      check("sat_code", 2, obs_code[2], 0);
      check("sat_set",  2, obs_flag[2], 1);
      cycle(1'b1, 1'b1, 1'b0, 0, 1'b1);
      check("set_wins", 2, obs_flag[2], 1);
      cycle(1'b1, 1'b1, 1'b1, 0, 1'b0);
      check("old_x",    2, obs_flag[2], 1);
      cycle(1'b1, 1'b1, 1'b0, 0, 1'b1);
      check("sat_clr",  2, obs_flag[2], 0);
      for (int n = 0; n < 12; n++) cycle(1'b1, 1'b1, 1'b0, 0, 1'b0);
      check("no_reset", 2, obs_flag[2], 0);

      // Second order at H/4, then switch to first order mid-stream.
      cycle(1'b1, 1'b1, 1'b1, HH / 4, 1'b0);
      for (int n = 0; n < 16; n++) cycle(1'b1, 1'b1, 1'b0, 0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         check("swap_code", i, obs_code[i], lv[i] / 2);
         check("swap_acc1", i, obs_acc1[i], 0);
         check("swap_acc2", i, obs_acc2[i], 0);
      end
      cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
      check("fresh1", 0, obs_code[0], 0);
      cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
      check("fresh2", 0, obs_code[0], 1);

      // Set the flag again, then reset asynchronously between edges.
      cycle(1'b0, 1'b1, 1'b1, -HH, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 0, 1'b0);
      check("pre_rst_flag", 2, obs_flag[2], 1);
      #3;
      reset = 1'b0;
      model_reset();
      #1;
      check_reset("arst");
      @(posedge clk);
      #1;
      check_reset("arst_hold");
      reset = 1'b1;
      cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
      check("post_rst1", 0, obs_code[0], 0);
      cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
      check("post_rst2", 0, obs_code[0], 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/sd_multilevel_mod.md
# sd_multilevel_mod

Parametrised multi-level sigma-delta modulator. It is the successor to the two-piece ternary modulator: configurable input width, quantizer level count and accumulator width, with run-time selectable 1st/2nd loop order. Integrators saturate and report a sticky flag. It sits between the DDS/gain stage that produces the signed drive word and the output driver or DAC cell array, which consumes a binary code and its thermometer form.

## Interface
- BITWIDTH, 32, width of signed input word; full scale H = 2^(BITWIDTH-1)
- LEVELS, 2, quantizer levels L, legal 2..16; LW = clog2(L), minimum 1
- ACCW, BITWIDTH+4, signed integrator width; must be >= BITWIDTH+1

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- en  in  1  advance modulator one step when 1; freeze all loop state when 0
- order_sel  in  1  0 = first order, 1 = second order
- kin  in  BITWIDTH  signed input sample
- kin_valid  in  1  capture kin into held input register x_reg
- sat_clr  in  1  clear sticky saturation flag
- sd_code  out  LW  registered quantizer code, 0..L-1
- sd_therm  out  L-1  thermometer of sd_code: bit k = (sd_code > k)
- sat_flag  out  1  sticky, set when any integrator saturates

## Operation
- Constants, fixed at elaboration:
  - STEP = H/(L-1), truncating integer division.
  - Level of code q: y(q) = (2q-(L-1))*STEP.
  - Thresholds: t_k = (2k-(L-2))*STEP, for k = 0..L-2.
- Quantizer: quant(u) = count of k with u >= t_k. Compare as signed at ACCW width.
- Per enabled cycle, with y = y(sd_code) taken from the current register:
  - a1n = sat(acc1 + x_reg - y)
  - order 1: code input u = a1n
  - order 2: a2n = sat(acc2 + a1n - y); u = a2n
  - acc1 <= a1n; acc2 <= a2n (order 2 only, else holds 0); sd_code <= quant(u)
- Transfer functions:
  - order 1: Y = X + (1-z^-1)E
  - order 2: Y = X + (1-z^-1)^2 E
- sat(v): clamp to [-2^(ACCW-1), 2^(ACCW-1)-1].
  - Intermediates use at least ACCW+2 bits, so no wrap occurs before the clamp.
  - A clamp is active only when the pre-clamp value lies outside the range. A value equal to a bound is not saturation.
- sat_flag:
  - Set when any clamp is active on an enabled cycle.
  - sat_clr clears it.
  - If set and clear occur in the same cycle, set wins.
- kin_valid: x_reg <= kin on that edge, independent of en. x_reg holds otherwise.
- Order change: order_q registers order_sel. When order_sel != order_q, the next edge does all of the following, regardless of en:
  - order_q <= order_sel
  - acc1, acc2 <= 0
  - sd_code <= L/2 (integer division)
  - No loop update occurs on that edge.
- Recommended stable input range: |x| <= 0.75H for order 2. Saturation guarantees no wrap beyond that range.

## Timing
- Reset (reset = 0), applied immediately and asynchronously:
  - x_reg = 0, acc1 = acc2 = 0
  - sd_code = L/2, sd_therm = thermometer(L/2)
  - sat_flag = 0, order_q = 0
- Reset mid-stream discards all state. The first enabled edge after release computes from reset values.
- Latency:
  - kin captured at edge N is used in the loop update at edge N+1.
  - sd_code reflects the edge N+1 update immediately after that edge.
- sd_therm is combinational from sd_code, with no extra cycle.
- en = 0: acc1, acc2, sd_code and sat_flag hold. sat_clr still clears sat_flag.
- Simultaneous kin_valid and enabled update: the update uses the old x_reg, and the new value is used from the next edge.

## Test plan
- L=2, order 1, x=0, en held 1 after reset:
  - sd_code = 0,1,0,1,… starting at the first enabled edge
  - acc1 alternates -H, 0
- L=2, order 1, kin = H/2 loaded:
  - steady period-4 pattern 0,1,1,1 (ones density exactly 3/4)
  - sat_flag stays 0
- L=3, order 1, x=0:
  - sd_code constant 1, sd_therm = 2'b01
  - then kin = H/2: the code stream averages 1.5 and toggles only between codes 1 and 2
- ACCW=BITWIDTH+1, L=2, order 2, kin = -H:
  - first enabled edge gives acc2 = -2^BITWIDTH (clamped), sd_code = 0, sat_flag = 1
  - a sat_clr pulse while still saturating leaves flag = 1
  - kin = 0, then sat_clr: flag = 0 and no later set
- Run order 2 with x = H/4, then toggle order_sel to 0 mid-stream:
  - next edge gives acc1 = acc2 = 0 and sd_code = L/2
  - following edges match a fresh order-1 run
- Mid-stream checks:
  - Drop en for 5 cycles: outputs frozen, stream resumes exactly where it stopped.
  - Assert reset asynchronously between edges: outputs reach reset values without a clock edge.
